// File: rtl/com_bus_arbiter_pkg.sv
// Shared definitions for the coherence-bus arbiter: default sizing and
// the arbiter state encoding used alongside the cache defines.
package com_bus_arbiter_pkg;

    localparam int unsigned NUM_REQ_DEF  = 4;
    localparam int unsigned ID_W_DEF     = 2;
    localparam int unsigned MAX_HOLD_DEF = 64;
    localparam int unsigned CNT_W_DEF    = 7;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_GRANT   = 2'b01,
        ARB_RELEASE = 2'b10
    } arb_state_e;

endpackage

// File: rtl/com_bus_arbiter_rr_priority_pick.sv
// Combinational rotating-priority encoder: returns the first set request
// bit found when searching from ptr_i upwards, wrapping modulo N.
module rr_priority_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic            found_o,
    output logic [ID_W-1:0] winner_o
);

    // Walk the requests in rotated order and keep the first hit
    always_comb begin
        int unsigned idx;
        logic        hit;
        idx      = 0;
        hit      = 1'b0;
        winner_o = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr_i) + k) % N;
            if (!hit && (|(req_i & (N'(1) << idx)))) begin
                hit      = 1'b1;
                winner_o = ID_W'(idx);
            end
        end
        found_o = hit;
    end

endmodule

// File: rtl/com_bus_arbiter.sv
// Round-robin owner arbiter for the shared coherence bus. Grants are held
// until the owner drops its request, followed by one turnaround cycle so the
// tri-stated bus is released before the next owner drives it. Long tenures
// raise a single Bus_timeout pulse without revoking the grant.
module com_bus_arbiter
    import com_bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = NUM_REQ_DEF,
    parameter int unsigned ID_W     = ID_W_DEF,
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] Com_Bus_Req_proc,
    output logic [NUM_REQ-1:0] Com_Bus_Gnt_proc,
    output logic               Bus_busy,
    output logic [ID_W-1:0]    Bus_owner,
    output logic               Bus_timeout
);

    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic               to_q, to_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               pick_found;
    logic [ID_W-1:0]    pick_winner;
    logic               owner_req;
    logic [ID_W-1:0]    next_ptr;

    rr_priority_pick #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .req_i    (Com_Bus_Req_proc),
        .ptr_i    (ptr_q),
        .found_o  (pick_found),
        .winner_o (pick_winner)
    );

    // The registered grant is one-hot on the owner, so masking the requests
    // with it tells whether the owner is still requesting.
    assign owner_req = |(Com_Bus_Req_proc & gnt_q);
    assign next_ptr  = (owner_q == LAST_ID) ? '0 : owner_q + ID_W'(1);

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        owner_d = owner_q;
        to_d    = 1'b0;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;

        case (state_q)
            ARB_IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                if (pick_found) begin
                    state_d = ARB_GRANT;
                    owner_d = pick_winner;
                    gnt_d   = NUM_REQ'(1) << pick_winner;
                    busy_d  = 1'b1;
                    // Counter tracks visible grant cycles, so the first
                    // grant cycle already counts as one.
                    cnt_d   = CNT_ONE;
                    to_d    = (MAX_HOLD == 1);
                end
            end
            ARB_GRANT: begin
                if (owner_req) begin
                    if (cnt_q < HOLD_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                        to_d  = (cnt_q == HOLD_LAST);
                    end
                end else begin
                    state_d = ARB_RELEASE;
                    gnt_d   = '0;
                    ptr_d   = next_ptr;
                    cnt_d   = '0;
                end
            end
            ARB_RELEASE: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            to_q    <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            to_q    <= to_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Com_Bus_Gnt_proc = gnt_q;
    assign Bus_busy         = busy_q;
    assign Bus_owner        = owner_q;
    assign Bus_timeout      = to_q;

endmodule

// File: tb/tb_com_bus_arbiter.sv
// Bench for com_bus_arbiter: directed vector table, hand-written corner
// sequences and a scoreboarded random stress run against a behavioural model.
module tb_com_bus_arbiter;

    localparam int NR = 4;
    localparam int MH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NR-1:0] req = '0;
    logic [NR-1:0] gnt;
    logic          busy;
    logic [1:0]    owner;
    logic          to;

    int checks = 0;
    int errors = 0;

    com_bus_arbiter #(
        .NUM_REQ  (NR),
        .ID_W     (2),
        .MAX_HOLD (MH),
        .CNT_W    (3)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .Com_Bus_Req_proc (req),
        .Com_Bus_Gnt_proc (gnt),
        .Bus_busy         (busy),
        .Bus_owner        (owner),
        .Bus_timeout      (to)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic       busy;
        logic [1:0] owner;
        logic       to;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] sbq[$];

    // behavioural reference model state
    int         m_st, m_ptr, m_cnt;
    logic [3:0] m_gnt;
    logic       m_busy, m_to;
    logic [1:0] m_owner;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic [3:0] g, input logic b,
                       input logic [1:0] o, input logic t);
        vec_t v;
        v.req = r; v.gnt = g; v.busy = b; v.owner = o; v.to = t;
        tbl.push_back(v);
    endtask

    task automatic m_reset();
        m_st = 0; m_ptr = 0; m_cnt = 0;
        m_gnt = '0; m_busy = 1'b0; m_to = 1'b0; m_owner = '0;
        sbq.delete();
    endtask

    task automatic model_step(input logic [3:0] r);
        int idx;
        m_to = 1'b0;
        if (m_st == 0) begin
            m_gnt  = '0;
            m_busy = 1'b0;
            for (int k = 0; k < NR; k++) begin
                idx = (m_ptr + k) % NR;
                if (m_st == 0 && r[idx]) begin
                    m_st    = 1;
                    m_owner = 2'(idx);
                    m_gnt   = 4'(1 << idx);
                    m_busy  = 1'b1;
                    m_cnt   = 1;
                    m_to    = (MH == 1);
                end
            end
        end else if (m_st == 1) begin
            if (r[m_owner]) begin
                if (m_cnt < MH) begin
                    m_cnt++;
                    if (m_cnt == MH) m_to = 1'b1;
                end
            end else begin
                m_st  = 2;
                m_gnt = '0;
                m_ptr = (int'(m_owner) + 1) % NR;
                m_cnt = 0;
            end
        end else begin
            m_st   = 0;
            m_busy = 1'b0;
        end
    endtask

    // compare the expectation due now, drive r, queue the next expectation
    task automatic sb_cycle(input logic [3:0] r);
        logic [7:0] e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("scoreboard", {gnt, busy, owner, to}, e);
        end
        req = r;
        model_step(r);
        sbq.push_back({m_gnt, m_busy, m_owner, m_to});
        @(negedge clk);
    endtask

    task automatic sb_flush();
        logic [7:0] e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("scoreboard", {gnt, busy, owner, to}, e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        chk("reset_state", {gnt, busy, owner, to}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [3:0] r;
        logic [3:0] prev_g;
        int         held, zeros, tn;
        int         exp_order[5];
        int         hold_n[NR];
        int         len_n[NR];
        int         wait_n[NR];

        // req, gnt, busy, owner, timeout (MAX_HOLD = 4)
        add(4'b0000, 4'b0000, 0, 2'd0, 0);
        add(4'b0100, 4'b0100, 1, 2'd2, 0);
        add(4'b0100, 4'b0100, 1, 2'd2, 0);
        add(4'b0100, 4'b0100, 1, 2'd2, 0);
        add(4'b0100, 4'b0100, 1, 2'd2, 1);
        add(4'b0100, 4'b0100, 1, 2'd2, 0);
        add(4'b0000, 4'b0000, 1, 2'd2, 0);
        add(4'b0000, 4'b0000, 0, 2'd2, 0);
        add(4'b1000, 4'b1000, 1, 2'd3, 0);
        add(4'b0000, 4'b0000, 1, 2'd3, 0);
        add(4'b1001, 4'b0000, 0, 2'd3, 0);
        add(4'b1001, 4'b0001, 1, 2'd0, 0);
        add(4'b1000, 4'b0000, 1, 2'd0, 0);
        add(4'b1000, 4'b0000, 0, 2'd0, 0);
        add(4'b1000, 4'b1000, 1, 2'd3, 0);
        add(4'b0000, 4'b0000, 1, 2'd3, 0);
        add(4'b0000, 4'b0000, 0, 2'd3, 0);
        add(4'b0110, 4'b0010, 1, 2'd1, 0);
        add(4'b0110, 4'b0010, 1, 2'd1, 0);
        add(4'b0100, 4'b0000, 1, 2'd1, 0);
        add(4'b0100, 4'b0000, 0, 2'd1, 0);
        add(4'b0100, 4'b0100, 1, 2'd2, 0);
        add(4'b0000, 4'b0000, 1, 2'd2, 0);
        add(4'b0000, 4'b0000, 0, 2'd2, 0);

        do_reset();
        foreach (tbl[i]) begin
            req = tbl[i].req;
            @(negedge clk);
            chk($sformatf("vec%0d", i), {gnt, busy, owner, to},
                {tbl[i].gnt, tbl[i].busy, tbl[i].owner, tbl[i].to});
        end

        // timeout: cache 1 holds ten grant cycles, pulse on the 4th only
        do_reset();
        req = 4'b0010;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("hold_gnt", gnt, 4'b0010);
            chk("timeout", to, (k == MH));
        end
        req = '0;
        @(negedge clk);
        chk("hold_release", {gnt, busy}, {4'b0000, 1'b1});

        // async reset mid-grant drops the grant without a clock edge
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        chk("pre_reset_gnt", gnt, 4'b0100);
        #2 rst = 1'b1;
        #1 chk("async_reset", {gnt, busy}, 5'b0);
        req = 4'b0110;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_pick", {gnt, owner}, {4'b0010, 2'd1});

        // all caches request; each owner drops after three grant cycles
        do_reset();
        exp_order = '{0, 1, 2, 3, 0};
        held = 0; zeros = 0; tn = 0; prev_g = '0;
        for (int c = 0; c < 30; c++) begin
            if (gnt != 0 && prev_g == 0) begin
                if (tn < 5) chk("rr_order", owner, exp_order[tn]);
                if (tn > 0) chk("turnaround_gap", zeros, 2);
                tn++;
                zeros = 0;
            end
            if (gnt == 0 && tn > 0) zeros++;
            prev_g = gnt;
            r = 4'hF;
            if (m_gnt != 0) begin
                held++;
                if (held == 3) begin
                    r    = ~m_gnt;
                    held = 0;
                end
            end
            sb_cycle(r);
        end
        sb_flush();
        chk("tenures", (tn >= 5), 1);

        // random stress with scoreboard and invariant checks
        do_reset();
        for (int i = 0; i < NR; i++) begin
            hold_n[i] = 0; len_n[i] = 1; wait_n[i] = 0;
        end
        prev_g = '0;
        r      = '0;
        for (int c = 0; c < 10000; c++) begin
            chk("onehot0", $onehot0(gnt), 1);
            if (gnt != 0) chk("gnt_implies_busy", busy, 1);
            if (gnt != 0 && prev_g == 0) begin
                for (int i = 0; i < NR; i++) begin
                    if (gnt[i]) wait_n[i] = 0;
                    else if (req[i]) begin
                        wait_n[i]++;
                        chk("starvation", (wait_n[i] <= NR - 1), 1);
                    end
                end
            end
            prev_g = gnt;
            for (int i = 0; i < NR; i++) begin
                if (r[i] && m_gnt[i]) begin
                    hold_n[i]++;
                    if (hold_n[i] >= len_n[i]) r[i] = 1'b0;
                end else if (!r[i] && $urandom_range(0, 2) == 0) begin
                    r[i]      = 1'b1;
                    len_n[i]  = int'($urandom_range(1, 6));
                    hold_n[i] = 0;
                end
            end
            sb_cycle(r);
        end
        sb_flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
